// File: rtl/pcie_tx_mwr_req.sv
// Device-to-host DMA write requester: pops write commands, splits them into MWr requests
// bounded by max payload size and 4KB boundaries, reserves tx FIFO payload, hands off to tx engine.
module pcie_tx_mwr_req #(
  parameter int C_PCIE_ADDR_WIDTH = 48
) (
  input  logic                           pcie_user_clk,
  input  logic                           pcie_user_rst,
  input  logic [2:0]                     pcie_max_payload_size,
  output logic                           pcie_tx_cmd_rd_en,
  input  logic [C_PCIE_ADDR_WIDTH+8:0]   pcie_tx_cmd_rd_data,
  input  logic                           pcie_tx_cmd_empty_n,
  input  logic [11:0]                    pcie_tx_fifo_avail_dw,
  output logic                           pcie_tx_fifo_alloc,
  output logic [10:0]                    pcie_tx_fifo_alloc_len,
  output logic                           tx_dma_mwr_req,
  output logic [12:2]                    tx_dma_mwr_len,
  output logic [C_PCIE_ADDR_WIDTH-1:2]   tx_dma_mwr_addr,
  input  logic                           tx_dma_mwr_req_ack,
  output logic                           tx_cmd_done,
  output logic                           tx_busy,
  output logic [2:0]                     dbg_state
);

  localparam int AW = C_PCIE_ADDR_WIDTH - 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    CHK  = 3'd2,
    REQ  = 3'd3,
    NEXT = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t         state;
  logic [10:0]    rem;
  logic [10:0]    chunk;
  logic [AW-1:0]  cur;
  logic [10:0]    mps_dw;
  logic [10:0]    bnd_dw;
  logic [10:0]    next_chunk;

  assign dbg_state = state;

  // Chunk size is the smallest of remaining length, payload limit and distance to the next 4KB page.
  always_comb begin
    case (pcie_max_payload_size)
      3'd0:    mps_dw = 11'd32;
      3'd1:    mps_dw = 11'd64;
      default: mps_dw = 11'd128;
    endcase
    bnd_dw     = 11'd1024 - {1'b0, cur[9:0]};
    next_chunk = rem;
    if (mps_dw < next_chunk) next_chunk = mps_dw;
    if (bnd_dw < next_chunk) next_chunk = bnd_dw;
  end

  // Handshake: tx_dma_mwr_req is a valid that stays high with stable len/addr until the
  // cycle tx_dma_mwr_req_ack is sampled high; ack while req is low has no effect.
  always_ff @(posedge pcie_user_clk or posedge pcie_user_rst) begin
    if (pcie_user_rst) begin
      state                  <= IDLE;
      rem                    <= '0;
      chunk                  <= '0;
      cur                    <= '0;
      pcie_tx_cmd_rd_en      <= 1'b0;
      pcie_tx_fifo_alloc     <= 1'b0;
      pcie_tx_fifo_alloc_len <= '0;
      tx_dma_mwr_req         <= 1'b0;
      tx_dma_mwr_len         <= '0;
      tx_dma_mwr_addr        <= '0;
      tx_cmd_done            <= 1'b0;
      tx_busy                <= 1'b0;
    end else begin
      pcie_tx_cmd_rd_en  <= 1'b0;
      pcie_tx_fifo_alloc <= 1'b0;
      tx_cmd_done        <= 1'b0;
      case (state)
        IDLE: begin
          if (pcie_tx_cmd_empty_n) begin
            pcie_tx_cmd_rd_en <= 1'b1;
            tx_busy           <= 1'b1;
            rem               <= pcie_tx_cmd_rd_data[C_PCIE_ADDR_WIDTH+8:C_PCIE_ADDR_WIDTH-2];
            cur               <= pcie_tx_cmd_rd_data[C_PCIE_ADDR_WIDTH-3:0];
            state             <= LOAD;
          end
        end
        LOAD: begin
          if (rem == 11'd0) begin
            state <= DONE;
          end else begin
            chunk <= next_chunk;
            state <= CHK;
          end
        end
        CHK: begin
          if ({1'b0, chunk} <= pcie_tx_fifo_avail_dw) begin
            tx_dma_mwr_req  <= 1'b1;
            tx_dma_mwr_len  <= chunk;
            tx_dma_mwr_addr <= cur;
            state           <= REQ;
          end
        end
        REQ: begin
          if (tx_dma_mwr_req_ack) begin
            tx_dma_mwr_req         <= 1'b0;
            pcie_tx_fifo_alloc     <= 1'b1;
            pcie_tx_fifo_alloc_len <= chunk;
            state                  <= NEXT;
          end
        end
        NEXT: begin
          cur   <= cur + {{(AW-11){1'b0}}, chunk};
          rem   <= rem - chunk;
          state <= LOAD;
        end
        DONE: begin
          tx_cmd_done <= 1'b1;
          tx_busy     <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_tx_mwr_req.sv
// Bench for pcie_tx_mwr_req: command FIFO and tx data FIFO models, an expected-request queue
// built from the splitting rules, directed scenarios with literal expectations, then random traffic.
`timescale 1ns/1ps
module tb_pcie_tx_mwr_req;
  localparam int W  = 48;
  localparam int AW = W - 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [2:0]      mps = 3'd0;
  logic            rd_en;
  logic [W+8:0]    rd_data;
  logic            empty_n;
  logic [11:0]     avail;
  logic            alloc;
  logic [10:0]     alloc_len;
  logic            req;
  logic [10:0]     len;
  logic [AW-1:0]   addr;
  logic            ack = 1'b0;
  logic            done;
  logic            busy;
  logic [2:0]      dbg_state;

  pcie_tx_mwr_req #(.C_PCIE_ADDR_WIDTH(W)) dut (
    .pcie_user_clk          (clk),
    .pcie_user_rst          (rst),
    .pcie_max_payload_size  (mps),
    .pcie_tx_cmd_rd_en      (rd_en),
    .pcie_tx_cmd_rd_data    (rd_data),
    .pcie_tx_cmd_empty_n    (empty_n),
    .pcie_tx_fifo_avail_dw  (avail),
    .pcie_tx_fifo_alloc     (alloc),
    .pcie_tx_fifo_alloc_len (alloc_len),
    .tx_dma_mwr_req         (req),
    .tx_dma_mwr_len         (len),
    .tx_dma_mwr_addr        (addr),
    .tx_dma_mwr_req_ack     (ack),
    .tx_cmd_done            (done),
    .tx_busy                (busy),
    .dbg_state              (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // command FIFO model: written by stimulus, popped by the monitor
  logic [W+8:0] cmd_mem [0:63];
  int           wr_ptr = 0;
  int           rd_ptr = 0;
  assign empty_n = (wr_ptr != rd_ptr);
  assign rd_data = cmd_mem[rd_ptr % 64];

  // tx data FIFO model: avail = produced - reserved
  int prod_rand = 0;
  int prod_dir  = 0;
  int cons_total = 0;
  assign avail = 12'(prod_rand + prod_dir - cons_total);

  int ack_mode = 0;   // 0 always, 1 random, 2 held low
  bit prod_en  = 0;

  // scoreboard state
  logic [W+8:0]  exp_q [$];
  bit            active = 0;
  int            done_cnt = 0;
  bit            alloc_pend = 0;
  logic [10:0]   alloc_pend_len = '0;
  int            acc_gap = 100;
  int            rd_log [$];
  int            done_log [$];
  int            acc_cyc [$];
  logic [AW-1:0] acc_addr [$];
  int            acc_len [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // ---------------- drivers ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ack_mode)
        0:       ack = 1'b1;
        1:       ack = ($urandom_range(0, 99) < 60);
        default: ack = 1'b0;
      endcase
      if (prod_en && (prod_rand + prod_dir - cons_total) < 2000)
        prod_rand = prod_rand + $urandom_range(0, 40);
    end
  end

  task automatic push_cmd(input logic [AW-1:0] a, input int l);
    cmd_mem[wr_ptr % 64] = {11'(l), a};
    wr_ptr++;
  endtask

  task automatic set_avail(input int v);
    prod_dir = v - prod_rand + cons_total;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (n < budget) begin
      @(posedge clk);
      #2;
      if (wr_ptr == rd_ptr && !active && !busy && exp_q.size() == 0 && !alloc_pend && done_cnt == 0)
        break;
      n++;
    end
    if (n >= budget) fail_timeout("wait_idle");
  endtask

  task automatic wait_req(input int budget);
    int n;
    n = 0;
    while (!req && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!req) fail_timeout("wait_req");
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin : mon
    logic [W+8:0]  c;
    logic [W+8:0]  e;
    logic [AW-1:0] a;
    int            r, m, b, ch, n;
    bit            exp_done;
    if (rst) begin
      exp_q.delete();
      active     = 0;
      done_cnt   = 0;
      alloc_pend = 0;
      acc_gap    = 100;
    end else begin
      cyc++;
      exp_done = 0;
      if (done_cnt > 0) begin
        done_cnt--;
        exp_done = (done_cnt == 0);
      end
      chk("tx_cmd_done", done, exp_done);
      if (done) begin
        done_log.push_back(cyc);
        active = 0;
      end

      chk("alloc", alloc, alloc_pend);
      if (alloc_pend) chk("alloc_len", alloc_len, alloc_pend_len);
      if (alloc) cons_total += int'(alloc_len);
      alloc_pend = 0;

      if (rd_en) begin
        chk("rd_en_legal", {active, empty_n}, 2'b01);
        if (!active && empty_n) begin
          c = cmd_mem[rd_ptr % 64];
          rd_ptr++;
          rd_log.push_back(cyc);
          active = 1;
          a = c[AW-1:0];
          r = int'(c[W+8:AW]);
          m = (mps >= 3'd2) ? 128 : (32 << mps);
          n = 0;
          while (r > 0) begin
            b  = 1024 - int'(a[9:0]);
            ch = r;
            if (m < ch) ch = m;
            if (b < ch) ch = b;
            exp_q.push_back({11'(ch), a});
            a = a + AW'(ch);
            r = r - ch;
            n++;
          end
          if (n == 0) done_cnt = 2;
        end
      end
      chk("busy", busy, active);

      acc_gap++;
      if (req) begin
        if (exp_q.size() == 0) begin
          chk("req_unexpected", req, 1'b0);
        end else begin
          e = exp_q[0];
          chk("req_addr", addr, e[AW-1:0]);
          chk("req_len", len, e[W+8:AW]);
          chk("req_avail_ok", (avail >= {1'b0, len}), 1'b1);
          chk("req_spacing", (acc_gap >= 4), 1'b1);
          if (ack) begin
            void'(exp_q.pop_front());
            alloc_pend     = 1;
            alloc_pend_len = len;
            acc_gap        = 0;
            acc_cyc.push_back(cyc);
            acc_addr.push_back(addr);
            acc_len.push_back(int'(len));
            if (exp_q.size() == 0) done_cnt = 4;
          end
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    fail_timeout("watchdog");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int            ab, rb, db;
    logic [AW-1:0] ea [4];
    int            el [4];
    logic [AW-1:0] ra;
    int            rl, nb, kind;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_en", rd_en, 1'b0);
    chk("rst_alloc", alloc, 1'b0);
    chk("rst_alloc_len", alloc_len, 11'd0);
    chk("rst_req", req, 1'b0);
    chk("rst_len", len, 11'd0);
    chk("rst_addr", addr, '0);
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;

    // reset while a request is pending
    mps = 3'd0;
    set_avail(1024);
    ack_mode = 2;
    push_cmd(46'h100, 64);
    wait_req(30);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_req", req, 1'b0);
    chk("midrst_alloc", alloc, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_addr", addr, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    ack_mode = 0;
    repeat (10) @(negedge clk);
    chk("no_stale_req", req, 1'b0);
    chk("no_stale_busy", busy, 1'b0);

    // split by max payload: 0x1000, 100 dw, 128B
    ab = acc_cyc.size(); rb = rd_log.size(); db = done_log.size();
    set_avail(1024);
    push_cmd(46'h400, 100);
    wait_idle(200);
    ea[0] = 46'h400; ea[1] = 46'h420; ea[2] = 46'h440; ea[3] = 46'h460;
    el[0] = 32;      el[1] = 32;      el[2] = 32;      el[3] = 4;
    chk("split_count", acc_cyc.size() - ab, 4);
    if (acc_cyc.size() - ab == 4 && rd_log.size() > rb && done_log.size() > db) begin
      for (int i = 0; i < 4; i++) begin
        chk("split_addr", acc_addr[ab+i], ea[i]);
        chk("split_len", acc_len[ab+i], el[i]);
      end
      chk("split_first_latency", acc_cyc[ab] - rd_log[rb], 2);
      for (int i = 0; i < 3; i++) chk("split_spacing", acc_cyc[ab+i+1] - acc_cyc[ab+i], 4);
      chk("split_done_latency", done_log[db] - acc_cyc[ab+3], 4);
    end
    chk("split_done_count", done_log.size() - db, 1);

    // 4KB boundary: 0x0FF0, 16 dw, 512B
    ab = acc_cyc.size();
    mps = 3'd2;
    set_avail(1024);
    push_cmd(46'h3FC, 16);
    wait_idle(200);
    chk("bnd_count", acc_cyc.size() - ab, 2);
    if (acc_cyc.size() - ab == 2) begin
      chk("bnd_addr0", acc_addr[ab], 46'h3FC);
      chk("bnd_len0", acc_len[ab], 4);
      chk("bnd_addr1", acc_addr[ab+1], 46'h400);
      chk("bnd_len1", acc_len[ab+1], 12);
    end

    // data starvation
    mps = 3'd0;
    set_avail(10);
    push_cmd(46'h800, 32);
    repeat (12) @(negedge clk);
    chk("starve_req", req, 1'b0);
    @(posedge clk);
    #1 set_avail(32);
    @(negedge clk);
    chk("starve_req_same_cycle", req, 1'b0);
    @(negedge clk);
    chk("starve_req_next", req, 1'b1);
    chk("starve_len", len, 11'd32);
    @(negedge clk);
    chk("starve_alloc", alloc, 1'b1);
    chk("starve_alloc_len", alloc_len, 11'd32);
    wait_idle(100);

    // zero length command
    ab = acc_cyc.size(); rb = rd_log.size(); db = done_log.size();
    push_cmd(46'h123, 0);
    wait_idle(50);
    chk("zero_no_req", acc_cyc.size() - ab, 0);
    chk("zero_done_count", done_log.size() - db, 1);
    if (rd_log.size() > rb && done_log.size() > db)
      chk("zero_done_latency", done_log[db] - rd_log[rb], 2);

    // ack stall with two queued commands
    ab = acc_cyc.size(); rb = rd_log.size(); db = done_log.size();
    set_avail(1024);
    ack_mode = 2;
    push_cmd(46'h800, 8);
    push_cmd(46'hC00, 8);
    wait_req(30);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stall_req", req, 1'b1);
      chk("stall_addr", addr, 46'h800);
      chk("stall_len", len, 11'd8);
    end
    chk("stall_one_pop", rd_log.size() - rb, 1);
    ack_mode = 0;
    wait_idle(100);
    chk("b2b_pops", rd_log.size() - rb, 2);
    chk("b2b_reqs", acc_cyc.size() - ab, 2);
    if (rd_log.size() - rb == 2 && done_log.size() - db == 2 && acc_cyc.size() - ab == 2) begin
      chk("b2b_pop_after_done", rd_log[rb+1] - done_log[db], 1);
      chk("b2b_second_addr", acc_addr[ab+1], 46'hC00);
    end

    // randomized traffic
    prod_en  = 1;
    ack_mode = 1;
    for (int bt = 0; bt < 14; bt++) begin
      mps = 3'($urandom_range(0, 7));
      nb  = $urandom_range(1, 3);
      for (int k = 0; k < nb; k++) begin
        kind = $urandom_range(0, 9);
        ra = AW'({$urandom(), $urandom()});
        if (kind < 4) ra[9:0] = 10'(1024 - $urandom_range(1, 40));
        if (kind == 9) ra = {AW{1'b1}} - AW'($urandom_range(0, 50));
        if (kind == 0)      rl = $urandom_range(0, 3);
        else if (kind == 8) rl = $urandom_range(900, 1100);
        else                rl = $urandom_range(1, 300);
        push_cmd(ra, rl);
      end
      wait_idle(6000);
    end
    ack_mode = 0;
    wait_idle(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
